// File: rtl/enc_therm2gray_pipe_pkg.sv
// ----------------------------------------------------------------------------
// enc_therm2gray_pipe_pkg
//   Shared definitions for the flash ADC thermometer-to-Gray front end:
//   default code/counter widths and the small combinational helpers used by
//   the bubble filter and the Gray conversion stage.
//   No ports (package).
// ----------------------------------------------------------------------------
package enc_therm2gray_pipe_pkg;

  // Default output Gray width (31 comparators) and bubble counter width.
  localparam int GRAY_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  // Widest code the Gray helper handles; callers truncate to their width.
  localparam int CODE_MAX_W = 16;

  // 3-input majority vote used to suppress single-bit bubbles.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Binary to reflected Gray code; matches the downstream decoder's table.
  function automatic logic [CODE_MAX_W-1:0] bin2gray(input logic [CODE_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/enc_therm2gray_pipe_therm_bubble_fix.sv
// ----------------------------------------------------------------------------
// therm_bubble_fix
//   Combinational bubble filter for a raw thermometer code. Each corrected bit
//   is the majority of the raw bit and its two neighbours; below bit 0 the
//   code is treated as 1 and above the top bit as 0, so a clean thermometer
//   passes through unchanged.
// Ports:
//   raw_i   in   NUM_LVL  raw comparator outputs, bit0 = lowest threshold
//   corr_o  out  NUM_LVL  majority-corrected code
//   bub_o   out  1        corrected code differs from raw code
// ----------------------------------------------------------------------------
module therm_bubble_fix
  import enc_therm2gray_pipe_pkg::*;
#(
  parameter int NUM_LVL = 31
) (
  input  logic [NUM_LVL-1:0] raw_i,
  output logic [NUM_LVL-1:0] corr_o,
  output logic               bub_o
);

  logic [NUM_LVL+1:0] ext_s;
  logic [NUM_LVL-1:0] corr_s;

  // Pad with the virtual neighbours: a 1 below the lowest comparator and a
  // 0 above the highest one.
  assign ext_s = {1'b0, raw_i, 1'b1};

  // Majority of each comparator with its lower and upper neighbour.
  always_comb begin
    corr_s = '0;
    for (int i = 0; i < NUM_LVL; i++) begin
      corr_s[i] = maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
    end
  end

  assign corr_o = corr_s;
  assign bub_o  = (corr_s != raw_i);

endmodule

// File: rtl/enc_therm2gray_pipe.sv
// ----------------------------------------------------------------------------
// enc_therm2gray_pipe
//   Three-stage pipelined front end for the flash ADC: captures the raw
//   comparator thermometer code on a sample strobe, removes single-bit bubbles
//   by majority vote, counts the corrected ones and emits the level in Gray
//   code together with an overrange flag and bubble statistics.
//   S1 capture -> S2 bubble fix -> S3 popcount / Gray / flags / counter.
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset, every flop
//   samp_i     in   1        sample strobe, therm_i captured when high
//   therm_i    in   NUM_LVL  raw comparator outputs, bit0 = lowest threshold
//   valid_o    out  1        gray_o/ovr_o/bubble_o carry a new result
//   gray_o     out  GRAY_W   Gray code of the corrected level
//   ovr_o      out  1        corrected code all ones (top level)
//   bubble_o   out  1        raw sample needed correction
//   err_clr_i  in   1        synchronous clear of err_cnt_o (wins over +1)
//   err_cnt_o  out  CNT_W    saturating count of valid bubbled samples
// ----------------------------------------------------------------------------
module enc_therm2gray_pipe
  import enc_therm2gray_pipe_pkg::*;
#(
  parameter  int GRAY_W  = GRAY_W_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int NUM_LVL = (2**GRAY_W) - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               samp_i,
  input  logic [NUM_LVL-1:0] therm_i,
  output logic               valid_o,
  output logic [GRAY_W-1:0]  gray_o,
  output logic               ovr_o,
  output logic               bubble_o,
  input  logic               err_clr_i,
  output logic [CNT_W-1:0]   err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // S1
  logic [NUM_LVL-1:0] raw_r;
  logic               v1_r;
  // S2
  logic [NUM_LVL-1:0] corr_s;
  logic               bub_s;
  logic [NUM_LVL-1:0] corr_r;
  logic               bub_r;
  logic               v2_r;
  // S3
  logic [GRAY_W-1:0]  lvl_s;
  logic [GRAY_W-1:0]  gray_s;
  logic               ovr_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               valid_r;
  logic [GRAY_W-1:0]  gray_r;
  logic               ovr_r;
  logic               bubble_r;
  logic [CNT_W-1:0]   err_cnt_r;

  // S1: capture the raw code on strobe; the valid bit follows the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_r <= '0;
      v1_r  <= 1'b0;
    end else begin
      v1_r <= samp_i;
      if (samp_i) begin
        raw_r <= therm_i;
      end
    end
  end

  therm_bubble_fix #(
    .NUM_LVL (NUM_LVL)
  ) u_bubble_fix (
    .raw_i  (raw_r),
    .corr_o (corr_s),
    .bub_o  (bub_s)
  );

  // S2: register the corrected code and its bubble flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_r <= '0;
      bub_r  <= 1'b0;
      v2_r   <= 1'b0;
    end else begin
      corr_r <= corr_s;
      bub_r  <= bub_s;
      v2_r   <= v1_r;
    end
  end

  // Level is the ones-count of the corrected code, even if a multi-bit
  // sparkle left it non-monotonic; NUM_LVL always fits in GRAY_W bits.
  always_comb begin
    lvl_s = '0;
    for (int i = 0; i < NUM_LVL; i++) begin
      lvl_s = lvl_s + {{(GRAY_W-1){1'b0}}, corr_r[i]};
    end
  end

  assign gray_s = GRAY_W'(bin2gray(CODE_MAX_W'(lvl_s)));
  assign ovr_s  = &corr_r;

  // Saturating bubble counter; a clear in the same cycle drops the event.
  always_comb begin
    if (err_clr_i) begin
      cnt_nxt_s = '0;
    end else if (v2_r && bub_r && (err_cnt_r != CNT_MAX)) begin
      cnt_nxt_s = err_cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = err_cnt_r;
    end
  end

  // S3: results load only with a valid sample and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      gray_r    <= '0;
      ovr_r     <= 1'b0;
      bubble_r  <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      valid_r   <= v2_r;
      err_cnt_r <= cnt_nxt_s;
      if (v2_r) begin
        gray_r   <= gray_s;
        ovr_r    <= ovr_s;
        bubble_r <= bub_r;
      end
    end
  end

  assign valid_o   = valid_r;
  assign gray_o    = gray_r;
  assign ovr_o     = ovr_r;
  assign bubble_o  = bubble_r;
  assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_enc_therm2gray_pipe.sv
// ----------------------------------------------------------------------------
// tb_enc_therm2gray_pipe
//   Self-checking bench: two instances (16-bit and 4-bit bubble counter) share
//   the stimulus. A behavioural model (delay by sample slots, majority from
//   neighbour sums, $countones level, n^(n>>1)) predicts every output each
//   cycle; directed pins fix literal values for known codes.
// ----------------------------------------------------------------------------
module tb_enc_therm2gray_pipe;

  localparam int GW  = 5;
  localparam int NL  = 31;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          samp_i    = 1'b0;
  logic          err_clr_i = 1'b0;
  logic [NL-1:0] therm_i   = '0;

  logic          valid_a, ovr_a, bub_a;
  logic [GW-1:0] gray_a;
  logic [CW-1:0] cnt_a;
  logic          valid_b, ovr_b, bub_b;
  logic [GW-1:0] gray_b;
  logic [CW4-1:0] cnt_b;

  int n_cmp = 0;
  int n_mis = 0;

  // Directed expectations driven by the stimulus process.
  bit            pin_en     = 1'b0;
  logic [GW-1:0] pin_gray   = '0;
  bit            pin_ovr    = 1'b0;
  bit            pin_bub    = 1'b0;
  bit            pin_cnt_en = 1'b0;
  int            pin_cnt16  = 0;
  int            pin_cnt4   = 0;

  enc_therm2gray_pipe #(.GRAY_W(GW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .samp_i(samp_i), .therm_i(therm_i),
    .valid_o(valid_a), .gray_o(gray_a), .ovr_o(ovr_a), .bubble_o(bub_a),
    .err_clr_i(err_clr_i), .err_cnt_o(cnt_a)
  );

  enc_therm2gray_pipe #(.GRAY_W(GW), .CNT_W(CW4)) dut4 (
    .clk(clk), .rst_n(rst_n), .samp_i(samp_i), .therm_i(therm_i),
    .valid_o(valid_b), .gray_o(gray_b), .ovr_o(ovr_b), .bubble_o(bub_b),
    .err_clr_i(err_clr_i), .err_cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Corrected code: bit i is 1 when at least two of (i-1, i, i+1) are 1,
  // with a virtual 1 below bit 0 and a virtual 0 above bit NL-1.
  function automatic logic [NL-1:0] model_fix(input logic [NL-1:0] t);
    logic [NL-1:0] c;
    int lo, hi, mid;
    for (int i = 0; i < NL; i++) begin
      lo  = (i == 0)      ? 1 : int'(t[i-1]);
      hi  = (i == NL - 1) ? 0 : int'(t[i+1]);
      mid = int'(t[i]);
      c[i] = ((lo + mid + hi) >= 2);
    end
    return c;
  endfunction

  // Model state: samples captured one and two edges ago, expected outputs.
  bit            e1_v, e2_v;
  logic [NL-1:0] e1_t, e2_t;
  bit            ex_v, ex_ovr, ex_bub;
  int            ex_lvl;
  logic [GW-1:0] ex_gray;
  int            ex_cnt16, ex_cnt4;
  bit            prev_ok;
  int            prev_lvl;
  logic [GW-1:0] prev_gray;

  always @(posedge clk or negedge rst_n) begin
    logic [NL-1:0] c;
    int            lvl, g;
    bit            bub_now;
    if (!rst_n) begin
      e1_v = 1'b0; e2_v = 1'b0; e1_t = '0; e2_t = '0;
      ex_v = 1'b0; ex_ovr = 1'b0; ex_bub = 1'b0; ex_gray = '0; ex_lvl = 0;
      ex_cnt16 = 0; ex_cnt4 = 0; prev_ok = 1'b0;
    end else begin
      bub_now = 1'b0;
      ex_v = e2_v;
      if (e2_v) begin
        c       = model_fix(e2_t);
        lvl     = $countones(c);
        g       = lvl ^ (lvl >> 1);
        bub_now = (c != e2_t);
        ex_lvl  = lvl;
        ex_gray = g[GW-1:0];
        ex_ovr  = (lvl == NL);
        ex_bub  = bub_now;
      end
      if (err_clr_i) begin
        ex_cnt16 = 0; ex_cnt4 = 0;
      end else if (e2_v && bub_now) begin
        if (ex_cnt16 < (1 << CW) - 1)  ex_cnt16++;
        if (ex_cnt4  < (1 << CW4) - 1) ex_cnt4++;
      end
      e2_v = e1_v; e2_t = e1_t;
      e1_v = samp_i;
      if (samp_i) e1_t = therm_i;
    end
    #1;
    chk("valid_o", valid_a, ex_v);
    chk("gray_o", gray_a, ex_gray);
    chk("ovr_o", ovr_a, ex_ovr);
    chk("bubble_o", bub_a, ex_bub);
    chk("err_cnt_o", cnt_a, ex_cnt16);
    chk("valid_o_c4", valid_b, ex_v);
    chk("gray_o_c4", gray_b, ex_gray);
    chk("bubble_o_c4", bub_b, ex_bub);
    chk("err_cnt_o_c4", cnt_b, ex_cnt4);
    if (ex_v && valid_a) begin
      if (prev_ok && ((ex_lvl - prev_lvl == 1) || (prev_lvl - ex_lvl == 1)))
        chk("gray_adjacent_bits", $countones(gray_a ^ prev_gray), 1);
      prev_ok = 1'b1; prev_lvl = ex_lvl; prev_gray = gray_a;
    end else begin
      prev_ok = 1'b0;
    end
    if (pin_en) begin
      chk("pin_valid", valid_a, 1);
      chk("pin_gray", gray_a, pin_gray);
      chk("pin_ovr", ovr_a, pin_ovr);
      chk("pin_bubble", bub_a, pin_bub);
      chk("pin_model_gray", ex_gray, pin_gray);
    end
    if (pin_cnt_en) begin
      chk("pin_cnt16", cnt_a, pin_cnt16);
      chk("pin_cnt4", cnt_b, pin_cnt4);
      chk("pin_model_cnt4", ex_cnt4, pin_cnt4);
    end
  end

  // One strobed sample; its result is pinned on the edge two after capture.
  task automatic pulse_pin(input logic [NL-1:0] t, input logic [GW-1:0] g, input bit o,
                           input bit b, input bit cnt_en, input int cnt);
    @(negedge clk); samp_i = 1'b1; therm_i = t;
    @(negedge clk); samp_i = 1'b0;
    @(negedge clk);
    pin_gray = g; pin_ovr = o; pin_bub = b; pin_en = 1'b1;
    pin_cnt_en = cnt_en; pin_cnt16 = cnt; pin_cnt4 = cnt;
    @(negedge clk); pin_en = 1'b0; pin_cnt_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [NL-1:0] t;
    int n, k;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed codes with literal expectations.
    pulse_pin(31'h0000007F, 5'b00100, 1'b0, 1'b0, 1'b1, 0);
    pulse_pin(31'h7FFFFFFF, 5'b10000, 1'b1, 1'b0, 1'b0, 0);
    pulse_pin(31'h00000000, 5'b00000, 1'b0, 1'b0, 1'b0, 0);
    pulse_pin(31'h0000005F, 5'b00101, 1'b0, 1'b1, 1'b1, 1);
    repeat (3) @(negedge clk);

    // Level sweep 0..31 on consecutive cycles.
    for (int i = 0; i <= NL; i++) begin
      @(negedge clk);
      w = (32'd1 << i) - 32'd1;
      samp_i = 1'b1; therm_i = w[NL-1:0];
    end
    @(negedge clk); samp_i = 1'b0;
    repeat (4) @(negedge clk);

    // Saturation of the 4-bit counter, then clear against a bubble.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); samp_i = 1'b1; therm_i = 31'h0000005F;
    end
    @(negedge clk); samp_i = 1'b0;
    repeat (3) @(negedge clk);
    pin_cnt_en = 1'b1; pin_cnt16 = 20; pin_cnt4 = 15;
    @(negedge clk); pin_cnt_en = 1'b0;
    samp_i = 1'b1; therm_i = 31'h0000005F;
    @(negedge clk); samp_i = 1'b0;
    @(negedge clk); err_clr_i = 1'b1;
    @(negedge clk); err_clr_i = 1'b0;
    pin_cnt_en = 1'b1; pin_cnt16 = 0; pin_cnt4 = 0;
    @(negedge clk); pin_cnt_en = 1'b0;

    // Asynchronous reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); samp_i = 1'b1; therm_i = 31'h00000FFF;
    end
    @(negedge clk); samp_i = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Randomised traffic: clean levels, single/double flips, arbitrary codes.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      samp_i    = ($urandom_range(0, 9) < 7);
      err_clr_i = ($urandom_range(0, 49) == 0);
      n = int'($urandom_range(0, NL));
      w = (32'd1 << n) - 32'd1;
      t = w[NL-1:0];
      k = int'($urandom_range(0, 3));
      if (k == 1 || k == 2) t[$urandom_range(0, NL - 1)] ^= 1'b1;
      if (k == 2) t[$urandom_range(0, NL - 1)] ^= 1'b1;
      if (k == 3) begin
        w = $urandom;
        t = w[NL-1:0];
      end
      therm_i = t;
    end
    @(negedge clk); samp_i = 1'b0; err_clr_i = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
